// File: rtl/uart_frame_parser.sv
// uart_frame_parser: sync-hunting, length-prefixed, checksum-verified frame parser with buffered valid/ready output
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_LEN = 3'd1, S_PAYLOAD = 3'd2, S_CHECK = 3'd3, S_DRAIN = 3'd4;
  logic [2:0] state;
  logic [IW-1:0] len, idx;
  logic [7:0] sum;
  logic [TW-1:0] tcnt;
  logic [7:0] mem [MAX_LEN];
  logic busy, expired;
  assign busy = state == S_LEN || state == S_PAYLOAD || state == S_CHECK;
  // an arriving byte always beats a coincident expiry
  assign expired = busy && !rx_valid && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (state == S_PAYLOAD && rx_valid) mem[idx[AW-1:0]] <= rx_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      len <= '0;
      idx <= '0;
      sum <= '0;
      tcnt <= '0;
      pkt_data <= '0;
      pkt_valid <= 1'b0;
      pkt_last <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= 2'd0;
    end else begin
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      tcnt <= (rx_valid || !busy) ? '0 : tcnt + 1'b1;
      if (expired) begin
        state <= S_IDLE;
        frame_err <= 1'b1;
        err_code <= 2'd3;
      end else case (state)
        S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state <= S_LEN;
        S_LEN: if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            state <= S_IDLE;
            frame_err <= 1'b1;
            err_code <= 2'd0;
          end else begin
            len <= IW'(rx_data);
            sum <= rx_data;
            idx <= '0;
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (rx_valid) begin
          sum <= sum + rx_data;
          idx <= idx + 1'b1;
          if (idx == len - 1'b1) state <= S_CHECK;
        end
        S_CHECK: if (rx_valid) begin
          if (rx_data == sum) begin
            frame_ok <= 1'b1;
            pkt_valid <= 1'b1;
            pkt_data <= mem[AW'(0)];
            pkt_last <= len == IW'(1);
            idx <= IW'(1);
            state <= S_DRAIN;
          end else begin
            state <= S_IDLE;
            frame_err <= 1'b1;
            err_code <= 2'd1;
          end
        end
        S_DRAIN: begin
          if (rx_valid) begin
            frame_err <= 1'b1;
            err_code <= 2'd2;
          end
          // idx already points at the byte to present after this transfer
          if (pkt_valid && pkt_ready) begin
            if (pkt_last) begin
              pkt_valid <= 1'b0;
              pkt_last <= 1'b0;
              state <= S_IDLE;
            end else begin
              pkt_data <= mem[idx[AW-1:0]];
              pkt_last <= idx == len - 1'b1;
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Receive-side framing stage that sits directly downstream of the UART receiver. It consumes the receiver's byte and done-pulse outputs and hunts for a sync byte. It then collects a length-prefixed payload and verifies an 8-bit additive checksum. Only verified payloads are released to the application logic over a valid/ready byte stream; malformed frames are discarded and reported.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: maximum payload length in bytes (1..255); also the payload buffer depth.
- `TIMEOUT`, 1200: inter-byte timeout in `clk` cycles while a frame is in progress.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte, connected to the receiver's data output.
- `rx_valid`  in  1  one-cycle pulse, `rx_data` valid; connected to the receiver's done flag.
- `pkt_data`  out  8  payload byte to the consumer.
- `pkt_valid`  out  1  `pkt_data` valid.
- `pkt_ready`  in  1  consumer accepts the byte.
- `pkt_last`  out  1  marks the final payload byte; qualified by `pkt_valid`.
- `frame_ok`  out  1  one-cycle pulse when a frame passes its checksum.
- `frame_err`  out  1  one-cycle pulse on any frame error.
- `err_code`  out  2  cause of the most recent error: 0 bad length, 1 checksum mismatch, 2 overrun, 3 timeout. Held until the next error.

## Operation
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK.
- CHK is the 8-bit sum, mod 256, of LEN and all payload bytes. Carries are discarded.
- States:
  - IDLE: bytes not equal to SYNC_BYTE are ignored silently. SYNC_BYTE moves to LEN.
  - LEN: LEN of 0 or LEN > MAX_LEN gives error 0 and returns to IDLE. Otherwise store LEN, seed sum = LEN, clear index, go to PAYLOAD.
  - PAYLOAD: write byte to buffer[index], add it to sum, increment index. After the LEN-th byte go to CHECK.
  - CHECK: if CHK == sum, pulse `frame_ok` and go to DRAIN. Otherwise raise error 1 and go to IDLE.
  - DRAIN: present buffer[0..LEN-1] in order. After the last byte transfers, go to IDLE.
- A SYNC_BYTE value received in LEN, PAYLOAD or CHECK is treated as data; there is no resync mid-frame.
- Any `rx_valid` during DRAIN: byte dropped, error 2, DRAIN continues unaffected.
- Timeout:
  - A counter runs only in LEN, PAYLOAD and CHECK.
  - It clears on every `rx_valid` and on entering LEN.
  - Reaching TIMEOUT-1 without a byte gives error 3 and returns to IDLE; the partial frame is discarded.
- If `rx_valid` and timeout expiry coincide, the byte wins and no timeout is raised.
- Reset:
  - State IDLE.
  - `pkt_valid`, `pkt_last`, `frame_ok` and `frame_err` are 0.
  - `pkt_data` and `err_code` are 0.
  - Counters and sum are cleared.
  - Reset mid-DRAIN abandons the remaining bytes.

## Timing
- Every input is sampled on the rising edge of `clk`. `rx_valid` is assumed to be at most one cycle long; back-to-back pulses are handled.
- `frame_ok` pulses the cycle after the CHK byte is sampled. `pkt_valid` rises on the same cycle with `pkt_data` = payload byte 0.
- A transfer occurs on any cycle with `pkt_valid && pkt_ready`. The next byte appears the following cycle, giving full throughput at 1 byte per clock.
- While `pkt_ready` is low, `pkt_valid`, `pkt_data` and `pkt_last` stay stable.
- `pkt_last` is high only while byte LEN-1 is presented. `pkt_valid` drops the cycle after that byte transfers.
- `frame_err` pulses exactly once per error, the cycle after the causing byte or timeout. `err_code` updates on that same cycle.
- Latency from the CHK byte's `rx_valid` to the first `pkt_valid` is 1 cycle.
- Buffer index and length counters are sized `$clog2(MAX_LEN+1)` bits. The checksum register is 8 bits and wraps.

## Test plan
- Good frame: A5 03 11 22 33 69 with `pkt_ready`=1 → `frame_ok` pulse, then 11, 22, 33 on consecutive cycles, `pkt_last` on 33, no `frame_err`.
- Checksum wrap and backpressure: A5 02 FF 02 03, with `pkt_ready` toggling 0/1 → frame accepted (sum 0x103 → 0x03). Output is FF, 02, stable while stalled.
- Bad length and checksum: A5 00 → err_code 0. A5 11 (MAX_LEN=16) → err_code 0. A5 01 7E 00 → err_code 1 and no `pkt_valid`. A following valid frame is then received correctly.
- Garbage and embedded sync: 00 FF A5 02 A5 A5 4C → leading bytes ignored; payload A5, A5 delivered (02+A5+A5 = 0x14C → 0x4C).
- Overrun and timeout: while stalled in DRAIN, inject 55 → err_code 2 and original payload intact. A5 04 01 followed by TIMEOUT idle cycles → err_code 3, back to IDLE. A byte arriving exactly on the expiry cycle prevents the timeout.
- Reset mid-DRAIN (`reset` high for 1 cycle) → all outputs 0 next cycle; a subsequent good frame parses normally.
